dram_wr_arbiter: RTL and testbench

- Controller that owns the single write port of a 2^ADDR_W x DATA_W distributed-RAM array. The array is built from RAM64X1D (ADDR_W=6) or RAM128X1D (ADDR_W=7) primitives, one per data bit.
- Arbitrates two write requesters round-robin and registers the winning write onto the RAM write port.
- Zero-fills the whole array after reset or on request.
- Sequences the independent async read port (DPRA/DPO) into a registered, one-cycle-latency read.

---
 rtl/dram_wr_arbiter.sv | 143 ++++++++++++++
 tb/tb_dram_wr_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_wr_arbiter.sv
// Write-port owner for a distributed-RAM array: zero-fills after reset or clear_req, arbitrates two
// writers round-robin and registers reads. Define DRAM_WR_ARBITER_BYPASS_EN to forward pending writes to reads.
module dram_wr_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
) (
    input  logic              CLK,
    input  logic              ARST_N,
    input  logic              wr0_valid,
    output logic              wr0_ready,
    input  logic [ADDR_W-1:0] wr0_addr,
    input  logic [DATA_W-1:0] wr0_data,
    input  logic              wr1_valid,
    output logic              wr1_ready,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic [DATA_W-1:0] wr1_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_data_vld,
    input  logic              clear_req,
    output logic              init_busy,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [ADDR_W-1:0] ram_raddr,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              last_grant_q, last_grant_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_waddr_q, ram_waddr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_vld_q, rd_vld_d;
    logic              grant0, grant1;
    logic              bypass_hit;

    // Round-robin: on contention the requester that did not win last time is granted.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == RUN && !clear_req) begin
            if (wr0_valid && (!wr1_valid || last_grant_q)) begin
                grant0 = 1'b1;
            end else if (wr1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

`ifdef DRAM_WR_ARBITER_BYPASS_EN
    assign bypass_hit = ram_we_q && (ram_waddr_q == rd_addr);
`else
    assign bypass_hit = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        ram_we_d     = 1'b0;
        ram_waddr_d  = ram_waddr_q;
        ram_wdata_d  = ram_wdata_q;
        rd_data_d    = rd_data_q;
        rd_vld_d     = 1'b0;
        if (state_q == INIT) begin
            ram_we_d    = 1'b1;
            ram_waddr_d = cnt_q;
            ram_wdata_d = '0;
            if (cnt_q == LAST_ADDR) begin
                cnt_d   = '0;
                state_d = RUN;
            end else begin
                cnt_d = cnt_q + ADDR_W'(1);
            end
        end else begin
            if (grant0) begin
                ram_we_d     = 1'b1;
                ram_waddr_d  = wr0_addr;
                ram_wdata_d  = wr0_data;
                last_grant_d = 1'b0;
            end else if (grant1) begin
                ram_we_d     = 1'b1;
                ram_waddr_d  = wr1_addr;
                ram_wdata_d  = wr1_data;
                last_grant_d = 1'b1;
            end
            if (rd_en) begin
                rd_vld_d  = 1'b1;
                rd_data_d = bypass_hit ? ram_wdata_q : ram_rdata;
            end
            // A write already registered this cycle still commits before fill address 0.
            if (clear_req) begin
                state_d = INIT;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state_q      <= INIT;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            ram_we_q     <= 1'b0;
            ram_waddr_q  <= '0;
            ram_wdata_q  <= '0;
            rd_data_q    <= '0;
            rd_vld_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            ram_we_q     <= ram_we_d;
            ram_waddr_q  <= ram_waddr_d;
            ram_wdata_q  <= ram_wdata_d;
            rd_data_q    <= rd_data_d;
            rd_vld_q     <= rd_vld_d;
        end
    end

    assign wr0_ready   = grant0;
    assign wr1_ready   = grant1;
    assign init_busy   = (state_q == INIT);
    assign ram_we      = ram_we_q;
    assign ram_waddr   = ram_waddr_q;
    assign ram_wdata   = ram_wdata_q;
    assign ram_raddr   = rd_addr;
    assign rd_data     = rd_data_q;
    assign rd_data_vld = rd_vld_q;

endmodule

// File: tb/tb_dram_wr_arbiter.sv
// Self-checking bench for dram_wr_arbiter: behavioural distributed RAM, write/read scoreboards,
// and a reference model of arbitration and read-after-write visibility.
module tb_dram_wr_arbiter;

    localparam int AW    = 6;
    localparam int DW    = 8;
    localparam int DEPTH = 64;
`ifdef DRAM_WR_ARBITER_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          ARST_N;
    logic          wr0_valid, wr1_valid, wr0_ready, wr1_ready;
    logic [AW-1:0] wr0_addr, wr1_addr, rd_addr, ram_waddr, ram_raddr;
    logic [DW-1:0] wr0_data, wr1_data, rd_data, ram_wdata, ram_rdata;
    logic          rd_en, rd_data_vld, clear_req, init_busy, ram_we;

    logic [DW-1:0]    mem [DEPTH];
    logic [AW+DW-1:0] expWrQ[$];
    logic [DW-1:0]    expRdQ[$];
    logic [AW+DW-1:0] monWr;
    logic [DW-1:0]    monRd;
    int               checks = 0;
    int               errors = 0;

    logic          lastGrant;
    logic [DW-1:0] shadow [DEPTH];
    logic          pendValid;
    logic [AW-1:0] pendAddr;
    logic [DW-1:0] pendData;
    logic          rv0, rv1, rre;
    logic [AW-1:0] ra0, ra1, rra;
    logic [DW-1:0] rd0, rd1;

    dram_wr_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .CLK(CLK), .ARST_N(ARST_N),
        .wr0_valid(wr0_valid), .wr0_ready(wr0_ready), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_valid(wr1_valid), .wr1_ready(wr1_ready), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_data_vld(rd_data_vld),
        .clear_req(clear_req), .init_busy(init_busy),
        .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .ram_raddr(ram_raddr), .ram_rdata(ram_rdata)
    );

    always #5 CLK = ~CLK;

    // Behavioural RAM64X1D bank: synchronous write, asynchronous read.
    always @(posedge CLK) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
    end
    assign ram_rdata = mem[ram_raddr];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard consumers: every RAM write and every valid read is matched in order.
    always @(negedge CLK) begin
        if (ram_we === 1'b1) begin
            if (expWrQ.size() == 0) begin
                checkOutput("wrUnexpected", 32'(ram_we), 32'd0);
            end else begin
                monWr = expWrQ.pop_front();
                checkOutput("wrAddr", 32'(ram_waddr), 32'(monWr[AW+DW-1:DW]));
                checkOutput("wrData", 32'(ram_wdata), 32'(monWr[DW-1:0]));
            end
        end
        if (rd_data_vld === 1'b1) begin
            if (expRdQ.size() == 0) begin
                checkOutput("rdUnexpected", 32'(rd_data_vld), 32'd0);
            end else begin
                monRd = expRdQ.pop_front();
                checkOutput("rdData", 32'(rd_data), 32'(monRd));
            end
        end
    end

    task automatic pushFill();
        for (int i = 0; i < DEPTH; i++) expWrQ.push_back({AW'(i), DW'(0)});
    endtask

    task automatic resetModel();
        lastGrant = 1'b1;
        pendValid = 1'b0;
        pendAddr  = '0;
        pendData  = '0;
        for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
    endtask

    task automatic driveIdle();
        wr0_valid = 0; wr0_addr = '0; wr0_data = '0;
        wr1_valid = 0; wr1_addr = '0; wr1_data = '0;
        rd_en = 0; rd_addr = '0; clear_req = 0;
    endtask

    // One RUN-mode cycle: drive, check readies against the model, queue expected results.
    task automatic applyStimulus(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                                 input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                                 input logic rdEn, input logic [AW-1:0] rdA, input logic clr);
        logic g0, g1;
        @(posedge CLK);
        #1;
        wr0_valid = v0; wr0_addr = a0; wr0_data = d0;
        wr1_valid = v1; wr1_addr = a1; wr1_data = d1;
        rd_en = rdEn; rd_addr = rdA; clear_req = clr;
        g0 = !clr && v0 && (!v1 || lastGrant);
        g1 = !clr && v1 && (!v0 || !lastGrant);
        #1;
        checkOutput("wr0_ready", 32'(wr0_ready), 32'(g0));
        checkOutput("wr1_ready", 32'(wr1_ready), 32'(g1));
        if (rdEn) begin
            if (BYPASS && pendValid && pendAddr == rdA) expRdQ.push_back(pendData);
            else expRdQ.push_back(shadow[rdA]);
        end
        if (pendValid) shadow[pendAddr] = pendData;
        pendValid = g0 || g1;
        if (g0) begin
            pendAddr = a0; pendData = d0; lastGrant = 1'b0;
            expWrQ.push_back({a0, d0});
        end else if (g1) begin
            pendAddr = a1; pendData = d1; lastGrant = 1'b1;
            expWrQ.push_back({a1, d1});
        end
        if (clr) begin
            pendValid = 1'b0;
            for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
            pushFill();
        end
    endtask

    task automatic idle();
        applyStimulus(0, '0, '0, 0, '0, '0, 0, '0, 0);
    endtask

    task automatic waitFill();
        logic done;
        done = 1'b0;
        @(posedge CLK);
        #1;
        driveIdle();
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge CLK);
            #1;
            if (expWrQ.size() == 0 && init_busy == 1'b0) done = 1'b1;
        end
        checkOutput("fillDone", 32'(done), 32'd1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL globalTimeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        ARST_N = 1'b0;
        driveIdle();
        resetModel();
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'hEE;
        #12;
        checkOutput("rstRamWe", 32'(ram_we), 32'd0);
        checkOutput("rstWaddr", 32'(ram_waddr), 32'd0);
        checkOutput("rstWdata", 32'(ram_wdata), 32'd0);
        checkOutput("rstRdData", 32'(rd_data), 32'd0);
        checkOutput("rstRdVld", 32'(rd_data_vld), 32'd0);
        checkOutput("rstBusy", 32'(init_busy), 32'd1);

        // Initial fill with both requesters pushing: nothing may be accepted.
        pushFill();
        @(negedge CLK);
        ARST_N = 1'b1;
        wr0_valid = 1; wr1_valid = 1; rd_en = 1;
        for (int k = 1; k <= DEPTH; k++) begin
            @(posedge CLK);
            #1;
            if (k >= DEPTH - 1) driveIdle();
            #1;
            checkOutput("fillBusy", 32'(init_busy), 32'(k < DEPTH));
            checkOutput("fillRdy0", 32'(wr0_ready), 32'd0);
            checkOutput("fillRdy1", 32'(wr1_ready), 32'd0);
        end
        waitFill();

        // Contention: grants alternate starting with requester 0.
        for (int n = 0; n < 8; n++) begin
            applyStimulus(1, AW'(n + 10), DW'(8'hA0 + n), 1, AW'(n + 20), DW'(8'hB0 + n), 0, '0, 0);
        end
        idle();

        // Write then read two cycles later.
        applyStimulus(1, 6'd3, 8'h5A, 0, '0, '0, 0, '0, 0);
        idle();
        applyStimulus(0, '0, '0, 0, '0, '0, 1, 6'd3, 0);
        idle();

        // Read of an address whose write is still pending in the register.
        applyStimulus(0, '0, '0, 1, 6'd9, 8'h77, 0, '0, 0);
        applyStimulus(0, '0, '0, 0, '0, '0, 1, 6'd9, 0);
        idle();

        // Mixed traffic on a small address window to provoke collisions.
        for (int k = 0; k < 16; k++) begin
            rv0 = 1'($urandom_range(0, 1)); rv1 = 1'($urandom_range(0, 1)); rre = 1'($urandom_range(0, 1));
            ra0 = AW'($urandom_range(0, 3)); ra1 = AW'($urandom_range(0, 3)); rra = AW'($urandom_range(0, 3));
            rd0 = DW'($urandom); rd1 = DW'($urandom);
            applyStimulus(rv0, ra0, rd0, rv1, ra1, rd1, rre, rra, 0);
        end
        idle();
        idle();

        // Clear with a write just accepted: it commits, then the array is re-zeroed.
        applyStimulus(1, 6'd5, 8'h3C, 0, '0, '0, 0, '0, 0);
        applyStimulus(1, 6'd6, 8'h11, 1, 6'd7, 8'h22, 0, '0, 1);
        waitFill();
        applyStimulus(0, '0, '0, 0, '0, '0, 1, 6'd5, 0);
        idle();
        idle();

        // Reset in the middle of the fill, at address 20.
        ARST_N = 1'b0;
        driveIdle();
        resetModel();
        expWrQ.delete();
        #20;
        pushFill();
        @(negedge CLK);
        ARST_N = 1'b1;
        repeat (21) @(posedge CLK);
        #1;
        checkOutput("midFillAddr", 32'(ram_waddr), 32'd20);
        checkOutput("midFillWe", 32'(ram_we), 32'd1);
        ARST_N = 1'b0;
        #1;
        checkOutput("midRstWe", 32'(ram_we), 32'd0);
        checkOutput("midRstBusy", 32'(init_busy), 32'd1);
        checkOutput("midRstAddr", 32'(ram_waddr), 32'd0);
        expWrQ.delete();
        #20;
        pushFill();
        @(negedge CLK);
        ARST_N = 1'b1;
        waitFill();
        applyStimulus(1, 6'd40, 8'hC1, 1, 6'd41, 8'hD1, 0, '0, 0);
        applyStimulus(1, 6'd42, 8'hC2, 1, 6'd43, 8'hD2, 1, 6'd40, 0);
        applyStimulus(0, '0, '0, 0, '0, '0, 1, 6'd41, 0);
        idle();
        idle();

        checkOutput("wrQEmpty", 32'(expWrQ.size()), 32'd0);
        checkOutput("rdQEmpty", 32'(expRdQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
